// File: rtl/gdp_scheduler_pkg.sv
// Shared types and defaults for the GDP frame scheduler.
//   num      : signed 16-bit feature / score value
//   state_t  : scheduler FSM states
//   N_*      : default parameter values used by gdp_scheduler
package gdp_scheduler_pkg;

    typedef logic signed [15:0] num;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int N_COMPONENTS   = 5;
    localparam int N_SENONES      = 10;
    localparam int TIMEOUT_CYCLES = 64;

    // Most negative score; running maximum starts here so any score beats it.
    localparam num NUM_MIN  = 16'sh8000;
    localparam num NUM_ZERO = 16'sh0000;

endpackage

// File: rtl/gdp_scheduler_max_tracker.sv
// score_max_tracker: running maximum of the scores of one frame.
//   clear        : start of a new frame, forget the previous maximum
//   valid/idx/score : one accepted score
//   max_score/max_idx : current maximum (NUM_MIN / 0 before any score)
// The first score of a frame is always taken; later ones only when strictly
// greater (signed), or equal with a lower index, so ties keep the first seen.
module score_max_tracker
    import gdp_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       valid,
    input  logic [7:0] idx,
    input  num         score,
    output num         max_score,
    output logic [7:0] max_idx
);

    logic       has_r;
    num         max_r;
    logic [7:0] idx_r;
    logic       take_s;

    // Decide whether the incoming score replaces the current maximum.
    always_comb begin
        take_s = 1'b0;
        if (!has_r) begin
            take_s = 1'b1;
        end else if (score > max_r) begin
            take_s = 1'b1;
        end else if ((score == max_r) && (idx < idx_r)) begin
            take_s = 1'b1;
        end else begin
            take_s = 1'b0;
        end
    end

    // Maximum registers, re-armed at every frame start.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            has_r <= 1'b0;
            max_r <= NUM_MIN;
            idx_r <= 8'd0;
        end else if (valid && take_s) begin
            has_r <= 1'b1;
            max_r <= score;
            idx_r <= idx;
        end
    end

    assign max_score = max_r;
    assign max_idx   = idx_r;

endmodule

// File: rtl/gdp_scheduler.sv
// gdp_scheduler: feeds feature frames to a GDP controller and collects the
// senone scores it returns.
//   frame_valid/frame_ready/frame_x : frame input, one-entry prefetch slot
//   new_vector_available/x          : start pulse and vector for the GDP
//   senone_idx/score/score_ready/gdp_idle/last_senone : GDP results
//   score_we/score_addr/score_data  : score RAM write port
//   best_score/best_idx             : maximum of the last completed frame
//   frame_done/busy/error/frame_count : status
module gdp_scheduler
    import gdp_scheduler_pkg::*;
#(
    parameter int n_components   = N_COMPONENTS,
    parameter int n_senones      = N_SENONES,
    parameter int timeout_cycles = TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  num          frame_x [n_components],
    output logic        new_vector_available,
    output num          x [n_components],
    input  logic [7:0]  senone_idx,
    input  num          senone_score,
    input  logic        score_ready,
    input  logic        gdp_idle,
    input  logic        last_senone,
    output logic        score_we,
    output logic [7:0]  score_addr,
    output logic [15:0] score_data,
    output num          best_score,
    output logic [7:0]  best_idx,
    output logic        frame_done,
    output logic        busy,
    output logic        error,
    output logic [15:0] frame_count
);

    localparam logic [15:0] WD_LAST   = 16'(timeout_cycles - 1);
    localparam logic [15:0] SEN_COUNT = 16'(n_senones);

    state_t      state_r, state_nxt_s;
    logic        slot_full_r;
    num          slot_x_r [n_components];
    num          x_r [n_components];
    logic        nva_r, score_ready_d_r, we_r;
    logic [7:0]  addr_r, best_idx_r;
    logic [15:0] data_r, frame_count_r, wd_r, senone_cnt_r;
    num          best_score_r;
    logic        frame_done_r, busy_r, error_r;

    logic        handshake_s, score_event_s, collect_ev_s, last_ev_s;
    logic        timeout_s, launch_s, err_set_s;
    num          trk_score_s;
    logic [7:0]  trk_idx_s;

    assign handshake_s   = frame_valid & ~slot_full_r;
    assign score_event_s = score_ready & ~score_ready_d_r;
    assign collect_ev_s  = score_event_s & (state_r == COLLECT);
    assign last_ev_s     = collect_ev_s & last_senone;
    assign timeout_s     = (state_r == COLLECT) & ~score_event_s & (wd_r == WD_LAST);
    assign err_set_s     = (last_ev_s && ((senone_cnt_r + 16'd1) != SEN_COUNT))
                         | timeout_s
                         | (score_event_s && (state_r == IDLE));

    // Next-state decision; DONE may launch straight from a same-cycle handshake.
    always_comb begin
        state_nxt_s = state_r;
        launch_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (slot_full_r && gdp_idle) begin
                    state_nxt_s = LAUNCH;
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LAUNCH:  state_nxt_s = COLLECT;
            COLLECT: begin
                if (last_ev_s || timeout_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            DONE: begin
                if ((slot_full_r || handshake_s) && gdp_idle) begin
                    state_nxt_s = LAUNCH;
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Scheduler state, prefetch slot, RAM write port, watchdog and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            slot_full_r     <= 1'b0;
            nva_r           <= 1'b0;
            score_ready_d_r <= 1'b0;
            we_r            <= 1'b0;
            addr_r          <= 8'd0;
            data_r          <= 16'd0;
            best_score_r    <= NUM_MIN;
            best_idx_r      <= 8'd0;
            frame_done_r    <= 1'b0;
            busy_r          <= 1'b0;
            error_r         <= 1'b0;
            frame_count_r   <= 16'd0;
            wd_r            <= 16'd0;
            senone_cnt_r    <= 16'd0;
            for (int i = 0; i < n_components; i++) begin
                x_r[i]      <= NUM_ZERO;
                slot_x_r[i] <= NUM_ZERO;
            end
        end else begin
            state_r         <= state_nxt_s;
            busy_r          <= (state_nxt_s != IDLE);
            nva_r           <= launch_s;
            score_ready_d_r <= score_ready;

            // A launch with an empty slot forwards the frame being handed over.
            if (launch_s) begin
                if (slot_full_r) begin
                    x_r <= slot_x_r;
                end else begin
                    x_r <= frame_x;
                end
                slot_full_r <= 1'b0;
            end else if (handshake_s) begin
                slot_x_r    <= frame_x;
                slot_full_r <= 1'b1;
            end

            we_r <= collect_ev_s;
            if (collect_ev_s) begin
                addr_r <= senone_idx;
                data_r <= senone_score;
            end

            if (launch_s) begin
                senone_cnt_r <= 16'd0;
            end else if (collect_ev_s) begin
                senone_cnt_r <= senone_cnt_r + 16'd1;
            end

            if ((state_r != COLLECT) || collect_ev_s) begin
                wd_r <= 16'd0;
            end else begin
                wd_r <= wd_r + 16'd1;
            end

            if (err_set_s) begin
                error_r <= 1'b1;
            end

            frame_done_r <= (state_r == DONE);
            if (state_r == DONE) begin
                best_score_r  <= trk_score_s;
                best_idx_r    <= trk_idx_s;
                frame_count_r <= frame_count_r + 16'd1;
            end
        end
    end

    score_max_tracker u_max (
        .clk       (clk),
        .reset     (reset),
        .clear     (launch_s),
        .valid     (collect_ev_s),
        .idx       (senone_idx),
        .score     (senone_score),
        .max_score (trk_score_s),
        .max_idx   (trk_idx_s)
    );

    assign frame_ready          = ~slot_full_r;
    assign new_vector_available = nva_r;
    assign x                    = x_r;
    assign score_we             = we_r;
    assign score_addr           = addr_r;
    assign score_data           = data_r;
    assign best_score           = best_score_r;
    assign best_idx             = best_idx_r;
    assign frame_done           = frame_done_r;
    assign busy                 = busy_r;
    assign error                = error_r;
    assign frame_count          = frame_count_r;

endmodule

// File: tb/tb_gdp_scheduler.sv
// Directed bench for gdp_scheduler with hand-computed expectations.
module tb_gdp_scheduler;
    import gdp_scheduler_pkg::*;

    logic        clk, reset, frame_valid, frame_ready, new_vector_available;
    num          frame_x [5];
    num          x [5];
    logic [7:0]  senone_idx;
    num          senone_score;
    logic        score_ready, gdp_idle, last_senone;
    logic        score_we;
    logic [7:0]  score_addr, best_idx;
    logic [15:0] score_data, frame_count;
    num          best_score;
    logic        frame_done, busy, error;

    int          n_vec = 0;
    int          n_bad = 0;
    int          wr_n = 0;
    int          done_n = 0;
    logic [7:0]  wr_addr [256];
    logic [15:0] wr_data [256];
    logic [15:0] sc [10];
    num          vec_a [5];
    num          vec_b [5];
    num          vec_c [5];

    gdp_scheduler dut (
        .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_x(frame_x), .new_vector_available(new_vector_available), .x(x),
        .senone_idx(senone_idx), .senone_score(senone_score), .score_ready(score_ready),
        .gdp_idle(gdp_idle), .last_senone(last_senone), .score_we(score_we),
        .score_addr(score_addr), .score_data(score_data), .best_score(best_score),
        .best_idx(best_idx), .frame_done(frame_done), .busy(busy), .error(error),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record RAM writes and completion pulses away from the active edge.
    always @(negedge clk) begin
        if (score_we) begin
            wr_addr[wr_n % 256] = score_addr;
            wr_data[wr_n % 256] = score_data;
            wr_n = wr_n + 1;
        end
        if (frame_done) done_n = done_n + 1;
    end

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake a frame from IDLE and check the two-cycle launch latency.
    task automatic send_frame(input num v [5]);
        frame_x     = v;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        check_eq("lat_hs_nva", 16'(new_vector_available), 16'd0);
        step();
        check_eq("lat_launch_nva", 16'(new_vector_available), 16'd1);
        for (int k = 0; k < 5; k++) check_eq("x_launch", x[k], v[k]);
    endtask

    // Called in the LAUNCH cycle; plays n scores from sc[], optional 3-cycle
    // hold on the first one and a prefetch of vec_b during the third.
    task automatic play_frame(input int n, input bit hold3, input bit prefetch);
        step();
        for (int i = 0; i < n; i++) begin
            score_ready  = 1'b1;
            senone_idx   = 8'(i);
            senone_score = sc[i];
            last_senone  = (i == n - 1);
            if (prefetch && i == 2) begin
                frame_x     = vec_b;
                frame_valid = 1'b1;
            end
            step();
            frame_valid = 1'b0;
            if (prefetch && i == 2) check_eq("prefetch_ready", 16'(frame_ready), 16'd0);
            if (hold3 && i == 0) begin
                step();
                step();
            end
            score_ready = 1'b0;
            last_senone = 1'b0;
            step();
        end
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (!frame_done && cyc < limit) begin
            step();
            cyc++;
        end
        check_eq("done_seen", 16'(frame_done), 16'd1);
    endtask

    initial begin
        int cyc, base, dbase;
        reset = 1'b1; frame_valid = 1'b0; score_ready = 1'b0; gdp_idle = 1'b1;
        last_senone = 1'b0; senone_idx = 8'd0; senone_score = 16'sh0000;
        for (int k = 0; k < 5; k++) begin
            frame_x[k] = 16'sh0000;
            vec_a[k] = num'(16'h0101 * (k + 1));
            vec_b[k] = num'(16'h0A00 + k);
            vec_c[k] = num'(16'h7000 - k);
        end
        step(); step();
        reset = 1'b0;
        step();
        check_eq("rst_ready", 16'(frame_ready), 16'd1);
        check_eq("rst_nva", 16'(new_vector_available), 16'd0);
        check_eq("rst_we", 16'(score_we), 16'd0);
        check_eq("rst_best", best_score, 16'h8000);
        check_eq("rst_best_idx", 16'(best_idx), 16'd0);
        check_eq("rst_busy", 16'(busy), 16'd0);
        check_eq("rst_error", 16'(error), 16'd0);
        check_eq("rst_count", frame_count, 16'd0);
        check_eq("rst_x0", x[0], 16'h0000);

        // Frame 1, with frame 2 prefetched during collection.
        sc = '{16'h12C0, 16'h1480, 16'h1380, 16'h1200, 16'h17C0,
               16'h0BC0, 16'h1000, 16'h15C0, 16'h14C0, 16'h14C0};
        base = wr_n; dbase = done_n;
        send_frame(vec_a);
        check_eq("collect_busy", 16'(busy), 16'd1);
        play_frame(10, 1'b0, 1'b1);
        wait_done(10, cyc);
        check_eq("f1_best", best_score, 16'h17C0);
        check_eq("f1_best_idx", 16'(best_idx), 16'd4);
        check_eq("f1_count", frame_count, 16'd1);
        check_eq("f1_error", 16'(error), 16'd0);
        check_eq("b2b_launch", 16'(new_vector_available), 16'd1);
        check_eq("b2b_x0", x[0], vec_b[0]);
        check_eq("b2b_x4", x[4], vec_b[4]);

        // Frame 2: held score_ready and a tie at the maximum.
        for (int i = 0; i < 8; i++) sc[i] = 16'(16'h0100 * (i + 1));
        sc[8] = 16'h14C0; sc[9] = 16'h14C0;
        play_frame(10, 1'b1, 1'b0);
        wait_done(10, cyc);
        check_eq("f2_best", best_score, 16'h14C0);
        check_eq("f2_best_idx", 16'(best_idx), 16'd8);
        check_eq("f2_count", frame_count, 16'd2);
        check_eq("f2_error", 16'(error), 16'd0);
        step();
        check_eq("f2_pulse_len", 16'(frame_done), 16'd0);
        check_eq("idle_busy", 16'(busy), 16'd0);
        check_eq("f12_writes", 16'(wr_n - base), 16'd20);
        check_eq("f12_dones", 16'(done_n - dbase), 16'd2);
        begin
            logic [15:0] f1 [10];
            f1 = '{16'h12C0, 16'h1480, 16'h1380, 16'h1200, 16'h17C0,
                   16'h0BC0, 16'h1000, 16'h15C0, 16'h14C0, 16'h14C0};
            for (int i = 0; i < 10; i++) begin
                check_eq("f1_wr_addr", 16'(wr_addr[(base + i) % 256]), 16'(i));
                check_eq("f1_wr_data", wr_data[(base + i) % 256], f1[i]);
                check_eq("f2_wr_addr", 16'(wr_addr[(base + 10 + i) % 256]), 16'(i));
                check_eq("f2_wr_data", wr_data[(base + 10 + i) % 256], sc[i]);
            end
        end

        // Frame 3: short frame.
        send_frame(vec_c);
        play_frame(7, 1'b0, 1'b0);
        wait_done(10, cyc);
        check_eq("short_error", 16'(error), 16'd1);
        check_eq("short_best", best_score, 16'h0700);
        check_eq("short_best_idx", 16'(best_idx), 16'd6);
        check_eq("short_count", frame_count, 16'd3);
        step();

        // Frame 4: GDP silent, watchdog forces DONE.
        reset = 1'b1; step(); reset = 1'b0; step();
        send_frame(vec_a);
        wait_done(100, cyc);
        check_eq("wd_cycles", 16'(cyc), 16'd66);
        check_eq("wd_error", 16'(error), 16'd1);
        check_eq("wd_best", best_score, 16'h8000);
        check_eq("wd_count", frame_count, 16'd1);
        step();

        // Frame 5: reset after three scores.
        send_frame(vec_b);
        step();
        for (int i = 0; i < 3; i++) begin
            score_ready = 1'b1; senone_idx = 8'(i); senone_score = 16'sh0300;
            step();
            score_ready = 1'b0;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("mid_we", 16'(score_we), 16'd0);
        check_eq("mid_done", 16'(frame_done), 16'd0);
        check_eq("mid_busy", 16'(busy), 16'd0);
        check_eq("mid_error", 16'(error), 16'd0);
        check_eq("mid_count", frame_count, 16'd0);
        check_eq("mid_ready", 16'(frame_ready), 16'd1);
        check_eq("mid_x0", x[0], 16'h0000);
        base = wr_n; dbase = done_n;
        for (int i = 0; i < 5; i++) step();
        check_eq("mid_no_wr", 16'(wr_n - base), 16'd0);
        check_eq("mid_no_done", 16'(done_n - dbase), 16'd0);

        // Frame 6: all-negative scores.
        for (int i = 0; i < 10; i++) sc[i] = 16'(16'hF000 + i);
        base = wr_n;
        send_frame(vec_c);
        play_frame(10, 1'b0, 1'b0);
        wait_done(10, cyc);
        check_eq("neg_best", best_score, 16'hF009);
        check_eq("neg_best_idx", 16'(best_idx), 16'd9);
        check_eq("neg_count", frame_count, 16'd1);
        check_eq("neg_error", 16'(error), 16'd0);
        step();
        check_eq("neg_writes", 16'(wr_n - base), 16'd10);

        // Score event while IDLE.
        base = wr_n;
        score_ready = 1'b1; senone_idx = 8'd3; senone_score = 16'sh0100;
        step();
        score_ready = 1'b0;
        step(); step();
        check_eq("idle_ev_error", 16'(error), 16'd1);
        check_eq("idle_ev_no_wr", 16'(wr_n - base), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
